sprite_line_scan: RTL and testbench
===================================

SPRITE_LINE_SCAN -- requirements
Module: sprite_line_scan

Interface
REQ-001 SHALL have parameter NUM_SPRITES, default 32, meaning attribute table depth, indexed by sprite_sel.
REQ-002 SHALL have parameter SLOTS, default 4, meaning maximum sprites reported per line.
REQ-003 SHALL have parameter SPRITE_H, default 16, meaning sprite height in lines.
REQ-004 SHALL have port clk  input  1  system clock.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port load_pos  input  1  write x_in and y_in into entry sprite_sel.
REQ-007 SHALL have port load_att  input  1  write visible_in into entry sprite_sel.
REQ-008 SHALL have port sprite_sel  input  5  target entry index.
REQ-009 SHALL have port x_in  input  10  sprite left column.
REQ-010 SHALL have port y_in  input  9  sprite top line.
REQ-011 SHALL have port visible_in  input  1  sprite enable.
REQ-012 SHALL have port line_start  input  1  one-cycle pulse that starts a scan for line_num.
REQ-013 SHALL have port line_num  input  9  line to evaluate; sampled only on line_start.
REQ-014 SHALL have port slot_valid  output  SLOTS  per-slot occupancy of the published list.
REQ-015 SHALL have port slot_id  output  5*SLOTS  sprite index per slot; slot k occupies bits [5k+4:5k].
REQ-016 SHALL have port slot_x  output  10*SLOTS  sprite x per slot.
REQ-017 SHALL have port slot_row  output  4*SLOTS  row within the sprite, equal to line - y.
REQ-018 SHALL have port scan_busy  output  1  high while a scan is in progress.
REQ-019 SHALL have port line_overflow  output  1  more than SLOTS hits on the published line.

Function
REQ-020 SHALL hold per entry: x (10 bits), y (9 bits), vis (1 bit), all in flops.
REQ-021 SHALL apply load_pos and load_att on the clock edge where they are high.
- Both high in the same cycle: both fields update.
- sprite_sel >= NUM_SPRITES: write ignored.
REQ-022 SHALL implement FSM states IDLE, SCAN and PUBLISH.
REQ-023 IDLE + line_start SHALL:
- latch line_num;
- set idx=0, hit count=0 and working overflow=0;
- clear working slots;
- enter SCAN.
REQ-024 SCAN SHALL examine entry idx once per cycle, with idx incremented each cycle.
- After idx = NUM_SPRITES-1 is examined, enter PUBLISH.
REQ-025 Hit SHALL be: vis=1 AND latched line >= y AND (line - y) < SPRITE_H.
- Comparison uses 10-bit unsigned arithmetic.
- No vertical wrap-around.
REQ-026 On a hit with count < SLOTS, SHALL store {idx, x, line-y} in working slot[count] and increment count.
- Slots fill in ascending index order, so the lowest index is in slot 0.
REQ-027 On a hit with count == SLOTS, SHALL set working overflow=1 and leave the slots unchanged.
REQ-028 PUBLISH SHALL copy working slots, valid bits and overflow to the outputs in one cycle, then return to IDLE.
REQ-029 Outputs SHALL change only in PUBLISH.
- Latency: outputs valid NUM_SPRITES+2 cycles after the line_start edge.
REQ-030 scan_busy SHALL be 1 in SCAN and PUBLISH, and 0 in IDLE.
REQ-031 line_start during SCAN or PUBLISH SHALL abort the current scan and restart per REQ-023.
- Outputs keep their previous published values.
REQ-032 A table write in the same cycle that SCAN examines that entry SHALL NOT affect that cycle's result.
- The scan sees the pre-write value.
- The new value is visible from the next cycle.

Reset
REQ-033 On rst all entries SHALL clear: x=0, y=0, vis=0.
REQ-034 On rst the state SHALL be IDLE, idx=0 and count=0.
REQ-035 On rst the outputs SHALL be: slot_valid=0, slot_id=0, slot_x=0, slot_row=0, scan_busy=0, line_overflow=0.
REQ-036 rst mid-scan SHALL discard the scan; rst overrides line_start and all writes in the same cycle.

Verification
REQ-037 Reset, then pulse line_start with line_num=5 -> after 34 cycles: slot_valid=0000, line_overflow=0.
REQ-038 Write sprite 2 (x=100, y=10, vis=1), then scan line 25 -> slot_valid=0001, slot_id0=2, slot_x0=100, slot_row0=15.
- Scan line 26 -> slot_valid=0000.
- Scan line 9 -> slot_valid=0000.
REQ-039 Make sprites 1, 3, 5, 7 and 9 visible with y=0, then scan line 0 -> slots hold ids 1, 3, 5, 7 and line_overflow=1.
REQ-040 Sprite 4 at y=0 with vis=0 -> not reported.
- load_att vis=1 during a scan at idx=4 -> still not reported.
- Next scan -> reported.
REQ-041 line_start at cycle 10 of a scan -> scan_busy stays high and results publish 34 cycles after the second pulse.
- Previous outputs are held until then.
REQ-042 Assert rst mid-scan with sprites visible -> all outputs 0, scan_busy=0, and the next scan reports no hits.

Source files
------------

// File: rtl/sprite_line_scan_if.sv
// Attribute-write, line-scan request and published slot-list signals for sprite_line_scan.
interface sprite_line_scan_if #(
  parameter int unsigned SLOTS = 4
) ();
  logic                 load_pos;
  logic                 load_att;
  logic [4:0]           sprite_sel;
  logic [9:0]           x_in;
  logic [8:0]           y_in;
  logic                 visible_in;
  logic                 line_start;
  logic [8:0]           line_num;
  logic [SLOTS-1:0]     slot_valid;
  logic [5*SLOTS-1:0]   slot_id;
  logic [10*SLOTS-1:0]  slot_x;
  logic [4*SLOTS-1:0]   slot_row;
  logic                 scan_busy;
  logic                 line_overflow;

  modport master (
    output load_pos, load_att, sprite_sel, x_in, y_in, visible_in, line_start, line_num,
    input  slot_valid, slot_id, slot_x, slot_row, scan_busy, line_overflow
  );

  modport slave (
    input  load_pos, load_att, sprite_sel, x_in, y_in, visible_in, line_start, line_num,
    output slot_valid, slot_id, slot_x, slot_row, scan_busy, line_overflow
  );
endinterface

// File: rtl/sprite_line_scan.sv
// Sprite attribute table plus a one-entry-per-cycle line scanner that publishes
// up to SLOTS hits (lowest index first) and an overflow flag per line.
module sprite_line_scan #(
  parameter int unsigned NUM_SPRITES = 32,
  parameter int unsigned SLOTS       = 4,
  parameter int unsigned SPRITE_H    = 16
) (
  input  logic              clk,
  input  logic              rst,
  sprite_line_scan_if.slave bus
);

  localparam int unsigned IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam int unsigned CNT_W = $clog2(SLOTS + 1);

  typedef enum logic [1:0] {IDLE, SCAN, PUBLISH} state_t;

  typedef struct packed {
    logic [4:0] id;
    logic [9:0] x;
    logic [3:0] row;
  } slot_t;

  logic [9:0]             x_mem [NUM_SPRITES];
  logic [8:0]             y_mem [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] vis_mem;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [8:0]          line_q, line_d;
  logic                wovf_q, wovf_d;
  slot_t               wslot_q [SLOTS];
  slot_t               wslot_d [SLOTS];
  logic [SLOTS-1:0]    wvalid_q, wvalid_d;

  logic [SLOTS-1:0]    valid_q, valid_d;
  logic [5*SLOTS-1:0]  id_q, id_d;
  logic [10*SLOTS-1:0] x_q, x_d;
  logic [4*SLOTS-1:0]  row_q, row_d;
  logic                busy_q, busy_d;
  logic                ovf_q, ovf_d;

  logic                sel_ok;
  logic [9:0]          line_w, y_w, diff;
  logic                hit;
  slot_t               hit_slot;

  assign sel_ok = 32'(bus.sprite_sel) < NUM_SPRITES;

  // Attribute table; a write lands at the edge, so a same-cycle scan sees the old entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        x_mem[i] <= '0;
        y_mem[i] <= '0;
      end
      vis_mem <= '0;
    end else if (sel_ok) begin
      if (bus.load_pos) begin
        x_mem[bus.sprite_sel] <= bus.x_in;
        y_mem[bus.sprite_sel] <= bus.y_in;
      end
      if (bus.load_att) begin
        vis_mem[bus.sprite_sel] <= bus.visible_in;
      end
    end
  end

  // Hit test in 10-bit unsigned arithmetic; line < y never wraps into a hit.
  always_comb begin
    line_w       = {1'b0, line_q};
    y_w          = {1'b0, y_mem[idx_q]};
    diff         = line_w - y_w;
    hit          = vis_mem[idx_q] && (line_w >= y_w) && (diff < 10'(SPRITE_H));
    hit_slot.id  = 5'(idx_q);
    hit_slot.x   = x_mem[idx_q];
    hit_slot.row = diff[3:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      line_q   <= '0;
      wovf_q   <= 1'b0;
      wvalid_q <= '0;
      for (int k = 0; k < SLOTS; k++) wslot_q[k] <= '0;
      valid_q  <= '0;
      id_q     <= '0;
      x_q      <= '0;
      row_q    <= '0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      line_q   <= line_d;
      wovf_q   <= wovf_d;
      wvalid_q <= wvalid_d;
      for (int k = 0; k < SLOTS; k++) wslot_q[k] <= wslot_d[k];
      valid_q  <= valid_d;
      id_q     <= id_d;
      x_q      <= x_d;
      row_q    <= row_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state and datapath; line_start from any state restarts the scan.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    line_d   = line_q;
    wovf_d   = wovf_q;
    wvalid_d = wvalid_q;
    for (int k = 0; k < SLOTS; k++) wslot_d[k] = wslot_q[k];
    valid_d  = valid_q;
    id_d     = id_q;
    x_d      = x_q;
    row_d    = row_q;
    ovf_d    = ovf_q;

    if (bus.line_start) begin
      state_d  = SCAN;
      idx_d    = '0;
      cnt_d    = '0;
      line_d   = bus.line_num;
      wovf_d   = 1'b0;
      wvalid_d = '0;
      for (int k = 0; k < SLOTS; k++) wslot_d[k] = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        SCAN: begin
          if (hit) begin
            if (cnt_q < CNT_W'(SLOTS)) begin
              for (int k = 0; k < SLOTS; k++) begin
                if (cnt_q == CNT_W'(k)) begin
                  wslot_d[k]  = hit_slot;
                  wvalid_d[k] = 1'b1;
                end
              end
              cnt_d = cnt_q + CNT_W'(1);
            end else begin
              wovf_d = 1'b1;
            end
          end
          if (idx_q == IDX_W'(NUM_SPRITES - 1)) begin
            state_d = PUBLISH;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        PUBLISH: begin
          for (int k = 0; k < SLOTS; k++) begin
            valid_d[k]        = wvalid_q[k];
            id_d[5*k +: 5]    = wslot_q[k].id;
            x_d[10*k +: 10]   = wslot_q[k].x;
            row_d[4*k +: 4]   = wslot_q[k].row;
          end
          ovf_d   = wovf_q;
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  assign bus.slot_valid    = valid_q;
  assign bus.slot_id       = id_q;
  assign bus.slot_x        = x_q;
  assign bus.slot_row      = row_q;
  assign bus.scan_busy     = busy_q;
  assign bus.line_overflow = ovf_q;

endmodule

// File: tb/tb_sprite_line_scan.sv
// Directed checks for sprite_line_scan: reset, hit window, overflow, write/scan race, restart, mid-scan reset.
module tb_sprite_line_scan;
  localparam int unsigned SLOTS = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  sprite_line_scan_if #(.SLOTS(SLOTS)) bus ();

  sprite_line_scan #(
    .NUM_SPRITES(32),
    .SLOTS      (SLOTS),
    .SPRITE_H   (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.load_pos   = 1'b0;
    bus.load_att   = 1'b0;
    bus.sprite_sel = '0;
    bus.x_in       = '0;
    bus.y_in       = '0;
    bus.visible_in = 1'b0;
    bus.line_start = 1'b0;
    bus.line_num   = '0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic write_sprite(input logic [4:0] sel, input logic [9:0] x,
                              input logic [8:0] y, input logic vis);
    bus.load_pos   = 1'b1;
    bus.load_att   = 1'b1;
    bus.sprite_sel = sel;
    bus.x_in       = x;
    bus.y_in       = y;
    bus.visible_in = vis;
    tick(1);
    drive_idle();
  endtask

  task automatic set_vis(input logic [4:0] sel, input logic vis);
    bus.load_att   = 1'b1;
    bus.sprite_sel = sel;
    bus.visible_in = vis;
    tick(1);
    drive_idle();
  endtask

  // Pulse line_start; returns just after the edge that takes it.
  task automatic start_line(input logic [8:0] n);
    bus.line_start = 1'b1;
    bus.line_num   = n;
    tick(1);
    bus.line_start = 1'b0;
  endtask

  // Full scan: 34 edges counting the line_start edge.
  task automatic scan_line(input logic [8:0] n);
    start_line(n);
    tick(33);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.slot_valid !== 4'b0000) begin n_bad++; $display("FAIL rst_valid: got %b want 0000", bus.slot_valid); end
    n_cmp++; if (bus.slot_id !== 20'd0) begin n_bad++; $display("FAIL rst_id: got %h want 0", bus.slot_id); end
    n_cmp++; if (bus.slot_x !== 40'd0) begin n_bad++; $display("FAIL rst_x: got %h want 0", bus.slot_x); end
    n_cmp++; if (bus.slot_row !== 16'd0) begin n_bad++; $display("FAIL rst_row: got %h want 0", bus.slot_row); end
    n_cmp++; if (bus.scan_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", bus.scan_busy); end
    n_cmp++; if (bus.line_overflow !== 1'b0) begin n_bad++; $display("FAIL rst_ovf: got %b want 0", bus.line_overflow); end
    start_line(9'd5);
    n_cmp++; if (bus.scan_busy !== 1'b1) begin n_bad++; $display("FAIL empty_busy_start: got %b want 1", bus.scan_busy); end
    tick(33);
    n_cmp++; if (bus.slot_valid !== 4'b0000) begin n_bad++; $display("FAIL empty_valid: got %b want 0000", bus.slot_valid); end
    n_cmp++; if (bus.line_overflow !== 1'b0) begin n_bad++; $display("FAIL empty_ovf: got %b want 0", bus.line_overflow); end
    n_cmp++; if (bus.scan_busy !== 1'b0) begin n_bad++; $display("FAIL empty_busy_end: got %b want 0", bus.scan_busy); end
  endtask

  task automatic test_single_hit();
    write_sprite(5'd2, 10'd100, 9'd10, 1'b1);
    start_line(9'd25);
    tick(32);
    n_cmp++; if (bus.scan_busy !== 1'b1) begin n_bad++; $display("FAIL hit_busy_publish: got %b want 1", bus.scan_busy); end
    n_cmp++; if (bus.slot_valid !== 4'b0000) begin n_bad++; $display("FAIL hit_early: got %b want 0000", bus.slot_valid); end
    tick(1);
    n_cmp++; if (bus.slot_valid !== 4'b0001) begin n_bad++; $display("FAIL hit25_valid: got %b want 0001", bus.slot_valid); end
    n_cmp++; if (bus.slot_id[4:0] !== 5'd2) begin n_bad++; $display("FAIL hit25_id: got %0d want 2", bus.slot_id[4:0]); end
    n_cmp++; if (bus.slot_x[9:0] !== 10'd100) begin n_bad++; $display("FAIL hit25_x: got %0d want 100", bus.slot_x[9:0]); end
    n_cmp++; if (bus.slot_row[3:0] !== 4'd15) begin n_bad++; $display("FAIL hit25_row: got %0d want 15", bus.slot_row[3:0]); end
    n_cmp++; if (bus.scan_busy !== 1'b0) begin n_bad++; $display("FAIL hit25_busy: got %b want 0", bus.scan_busy); end
    scan_line(9'd26);
    n_cmp++; if (bus.slot_valid !== 4'b0000) begin n_bad++; $display("FAIL line26_valid: got %b want 0000", bus.slot_valid); end
    scan_line(9'd9);
    n_cmp++; if (bus.slot_valid !== 4'b0000) begin n_bad++; $display("FAIL line9_valid: got %b want 0000", bus.slot_valid); end
    scan_line(9'd10);
    n_cmp++; if (bus.slot_valid !== 4'b0001) begin n_bad++; $display("FAIL line10_valid: got %b want 0001", bus.slot_valid); end
    n_cmp++; if (bus.slot_row[3:0] !== 4'd0) begin n_bad++; $display("FAIL line10_row: got %0d want 0", bus.slot_row[3:0]); end
  endtask

  task automatic test_bounds();
    write_sprite(5'd0, 10'd1023, 9'd500, 1'b1);
    scan_line(9'd511);
    n_cmp++; if (bus.slot_valid !== 4'b0001) begin n_bad++; $display("FAIL bottom_valid: got %b want 0001", bus.slot_valid); end
    n_cmp++; if (bus.slot_id[4:0] !== 5'd0) begin n_bad++; $display("FAIL bottom_id: got %0d want 0", bus.slot_id[4:0]); end
    n_cmp++; if (bus.slot_x[9:0] !== 10'd1023) begin n_bad++; $display("FAIL bottom_x: got %0d want 1023", bus.slot_x[9:0]); end
    n_cmp++; if (bus.slot_row[3:0] !== 4'd11) begin n_bad++; $display("FAIL bottom_row: got %0d want 11", bus.slot_row[3:0]); end
    scan_line(9'd3);
    n_cmp++; if (bus.slot_valid !== 4'b0000) begin n_bad++; $display("FAIL nowrap_valid: got %b want 0000", bus.slot_valid); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i < 10; i += 2) write_sprite(5'(i), 10'(10 * i), 9'd0, 1'b1);
    scan_line(9'd0);
    n_cmp++; if (bus.slot_valid !== 4'b1111) begin n_bad++; $display("FAIL ovf_valid: got %b want 1111", bus.slot_valid); end
    n_cmp++; if (bus.slot_id !== {5'd7, 5'd5, 5'd3, 5'd1}) begin n_bad++; $display("FAIL ovf_ids: got %h want %h", bus.slot_id, {5'd7, 5'd5, 5'd3, 5'd1}); end
    n_cmp++; if (bus.slot_x !== {10'd70, 10'd50, 10'd30, 10'd10}) begin n_bad++; $display("FAIL ovf_x: got %h want %h", bus.slot_x, {10'd70, 10'd50, 10'd30, 10'd10}); end
    n_cmp++; if (bus.slot_row !== 16'h0000) begin n_bad++; $display("FAIL ovf_row: got %h want 0000", bus.slot_row); end
    n_cmp++; if (bus.line_overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b want 1", bus.line_overflow); end
    set_vis(5'd9, 1'b0);
    scan_line(9'd0);
    n_cmp++; if (bus.slot_valid !== 4'b1111) begin n_bad++; $display("FAIL exact4_valid: got %b want 1111", bus.slot_valid); end
    n_cmp++; if (bus.line_overflow !== 1'b0) begin n_bad++; $display("FAIL exact4_ovf: got %b want 0", bus.line_overflow); end
  endtask

  task automatic test_att_during_scan();
    do_reset();
    write_sprite(5'd4, 10'd40, 9'd0, 1'b0);
    scan_line(9'd0);
    n_cmp++; if (bus.slot_valid !== 4'b0000) begin n_bad++; $display("FAIL hidden_valid: got %b want 0000", bus.slot_valid); end
    start_line(9'd3);
    tick(4);
    bus.load_att   = 1'b1;
    bus.sprite_sel = 5'd4;
    bus.visible_in = 1'b1;
    tick(1);
    drive_idle();
    tick(28);
    n_cmp++; if (bus.slot_valid !== 4'b0000) begin n_bad++; $display("FAIL race_valid: got %b want 0000", bus.slot_valid); end
    scan_line(9'd3);
    n_cmp++; if (bus.slot_valid !== 4'b0001) begin n_bad++; $display("FAIL after_race_valid: got %b want 0001", bus.slot_valid); end
    n_cmp++; if (bus.slot_id[4:0] !== 5'd4) begin n_bad++; $display("FAIL after_race_id: got %0d want 4", bus.slot_id[4:0]); end
    n_cmp++; if (bus.slot_x[9:0] !== 10'd40) begin n_bad++; $display("FAIL after_race_x: got %0d want 40", bus.slot_x[9:0]); end
    n_cmp++; if (bus.slot_row[3:0] !== 4'd3) begin n_bad++; $display("FAIL after_race_row: got %0d want 3", bus.slot_row[3:0]); end
  endtask

  task automatic test_back_to_back();
    start_line(9'd100);
    tick(9);
    n_cmp++; if (bus.scan_busy !== 1'b1) begin n_bad++; $display("FAIL restart_busy_pre: got %b want 1", bus.scan_busy); end
    start_line(9'd0);
    tick(32);
    n_cmp++; if (bus.scan_busy !== 1'b1) begin n_bad++; $display("FAIL restart_busy_mid: got %b want 1", bus.scan_busy); end
    n_cmp++; if (bus.slot_row[3:0] !== 4'd3) begin n_bad++; $display("FAIL restart_held_row: got %0d want 3", bus.slot_row[3:0]); end
    n_cmp++; if (bus.slot_valid !== 4'b0001) begin n_bad++; $display("FAIL restart_held_valid: got %b want 0001", bus.slot_valid); end
    tick(1);
    n_cmp++; if (bus.slot_valid !== 4'b0001) begin n_bad++; $display("FAIL restart_valid: got %b want 0001", bus.slot_valid); end
    n_cmp++; if (bus.slot_row[3:0] !== 4'd0) begin n_bad++; $display("FAIL restart_row: got %0d want 0", bus.slot_row[3:0]); end
    n_cmp++; if (bus.scan_busy !== 1'b0) begin n_bad++; $display("FAIL restart_busy_end: got %b want 0", bus.scan_busy); end
  endtask

  task automatic test_rst_mid_scan();
    start_line(9'd0);
    tick(9);
    rst            = 1'b1;
    bus.line_start = 1'b1;
    bus.line_num   = 9'd0;
    bus.load_pos   = 1'b1;
    bus.load_att   = 1'b1;
    bus.sprite_sel = 5'd6;
    bus.x_in       = 10'd60;
    bus.y_in       = 9'd0;
    bus.visible_in = 1'b1;
    tick(1);
    drive_idle();
    rst = 1'b0;
    n_cmp++; if (bus.slot_valid !== 4'b0000) begin n_bad++; $display("FAIL midrst_valid: got %b want 0000", bus.slot_valid); end
    n_cmp++; if ({bus.slot_id, bus.slot_x, bus.slot_row} !== 76'd0) begin n_bad++; $display("FAIL midrst_fields: got %h want 0", {bus.slot_id, bus.slot_x, bus.slot_row}); end
    n_cmp++; if (bus.scan_busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", bus.scan_busy); end
    n_cmp++; if (bus.line_overflow !== 1'b0) begin n_bad++; $display("FAIL midrst_ovf: got %b want 0", bus.line_overflow); end
    tick(40);
    n_cmp++; if ({bus.scan_busy, bus.slot_valid} !== 5'd0) begin n_bad++; $display("FAIL midrst_idle: got %b want 00000", {bus.scan_busy, bus.slot_valid}); end
    scan_line(9'd0);
    n_cmp++; if (bus.slot_valid !== 4'b0000) begin n_bad++; $display("FAIL midrst_rescan: got %b want 0000", bus.slot_valid); end
    n_cmp++; if (bus.line_overflow !== 1'b0) begin n_bad++; $display("FAIL midrst_rescan_ovf: got %b want 0", bus.line_overflow); end
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_single_hit();
    test_bounds();
    test_overflow();
    test_att_during_scan();
    test_back_to_back();
    test_rst_mid_scan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
